edit_controller: RTL and testbench
==================================

# edit_controller

Front-panel sequencer for the century clock. It turns debounced button pulses into the display-select (`mode_o`), field-blink (`blink_mode_o`, `tick_blink_o`), counter-freeze (`hold_o`) and field-increment controls. Those outputs drive the 7-segment display multiplexer and the time/date counter core. It owns the run/edit state machine, the blink phase generator and the edit inactivity timeout.

## Interface
Parameters:
- `BLINK_DIV`, default 25_000_000: clk cycles per blink half-period; must be ≥2.
- `TIMEOUT_S`, default 30: seconds of no button activity before edit mode is abandoned; must be ≥1.

Ports:
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `btn_mode_i` in 1: one-cycle pulse; toggles time/date view, or aborts an edit.
- `btn_set_i` in 1: one-cycle pulse; enters edit, or advances to the next field.
- `btn_inc_i` in 1: one-cycle pulse; increments the blinking field.
- `tick_1hz_i` in 1: one-cycle pulse once per second from the clock core.
- `mode_o` out 1: display select; 1 = time view, 0 = date view.
- `blink_mode_o` out 3: field under edit: 000 none, 001 sec, 010 min, 011 hour, 100 day, 101 month, 110 year.
- `tick_blink_o` out 1: blink phase; 1 = field blanked.
- `hold_o` out 1: 1 while any field is being edited; the core freezes counting.
- `inc_o` out 6: one-hot one-cycle increment strobe; bit0 sec, bit1 min, bit2 hour, bit3 day, bit4 month, bit5 year.

## Operation
- States: `RUN_TIME`, `RUN_DATE`, `ED_SEC`, `ED_MIN`, `ED_HOUR`, `ED_DAY`, `ED_MON`, `ED_YEAR`.
- Per-state outputs:
  - `mode_o` = 1 in `RUN_TIME`, `ED_SEC`, `ED_MIN`, `ED_HOUR`; 0 otherwise.
  - `blink_mode_o` = field code of the edit state; 000 in run states.
  - `hold_o` = 1 in all edit states.
- Input priority when pulses coincide: `btn_set_i` > `btn_mode_i` > `btn_inc_i` > timeout. Only the winner acts.
- `RUN_TIME`:
  - `btn_mode_i` → `RUN_DATE`.
  - `btn_set_i` → `ED_SEC`.
  - `btn_inc_i` ignored.
- `RUN_DATE`:
  - `btn_mode_i` → `RUN_TIME`.
  - `btn_set_i` → `ED_DAY`.
  - `btn_inc_i` ignored.
- `btn_set_i` advances the edit chain: `ED_SEC`→`ED_MIN`→`ED_HOUR`→`RUN_TIME`, and `ED_DAY`→`ED_MON`→`ED_YEAR`→`RUN_DATE`.
- `btn_mode_i` in any edit state aborts to the run state of the same group (time or date). Increments already issued stand.
- `btn_inc_i` in an edit state:
  - pulses the matching `inc_o` bit for exactly one cycle;
  - restarts the blink phase;
  - restarts the timeout.
- Timeout:
  - The idle counter clears on entry to any edit state and on any button pulse.
  - It increments on `tick_1hz_i` while in an edit state.
  - When it reaches `TIMEOUT_S`, the block returns to the group's run state.
- Blink generator:
  - In run states, the counter is held at 0 and `tick_blink_o` = 0.
  - In edit states, the counter runs 0..`BLINK_DIV`-1 and `tick_blink_o` toggles on each wrap.
  - On edit-state entry or `btn_inc_i`, the counter is 0 and `tick_blink_o` = 0, so a fresh value is visible immediately.
- Widths:
  - Blink counter is `$clog2(BLINK_DIV)` bits.
  - Idle counter is `$clog2(TIMEOUT_S+1)` bits and saturates, never wraps.

## Timing
- All outputs are registered.
- Reset values: state `RUN_TIME`, `mode_o`=1, `blink_mode_o`=000, `tick_blink_o`=0, `hold_o`=0, `inc_o`=0, both counters 0.
- Button pulse in cycle N: new state outputs and any `inc_o` strobe are visible in cycle N+1.
- `inc_o` is never asserted in two consecutive cycles unless `btn_inc_i` is.
- `inc_o` is zero in any cycle where the state changes.
- First `tick_blink_o` rise occurs `BLINK_DIV` cycles after edit entry.
- Timeout exit: the cycle after the `TIMEOUT_S`-th `tick_1hz_i`.
- `rst` asserted mid-edit: the next cycle is in reset values, with no `inc_o` strobe.

## Structure
- Shared package `century_clock_pkg` holds:
  - state enum;
  - `BLINK_*` field codes (000–110), shared with the display multiplexer;
  - `INC_*` one-hot bit indices, shared with the counter core.
- Sub-module `blink_gen`: blink counter and phase flop, with `clk`, `rst`, `en`, `restart` and `tick_blink` ports.
- FSM, timeout counter and `inc_o` decode live in `edit_controller`.

## Test plan
Sim overrides: `BLINK_DIV`=4, `TIMEOUT_S`=3.
- Reset, then `btn_mode_i` ×2 → `mode_o` 1→0→1, `blink_mode_o`=000 throughout, `hold_o`=0.
- `btn_set_i` ×4 from `RUN_TIME` → `blink_mode_o` 001, 010, 011, then 000 with `mode_o`=1; `hold_o` high during the three edit states only.
- In `ED_MON`, `btn_inc_i` ×2 → `inc_o`=010000 for one cycle each; `tick_blink_o` is 0 on the cycle after each pulse and first toggles 4 cycles later.
- In `ED_HOUR`, `btn_set_i` and `btn_inc_i` in the same cycle → state `RUN_TIME`, `inc_o` stays 0.
- In `ED_YEAR` with no buttons, 3 `tick_1hz_i` pulses → `RUN_DATE`, `blink_mode_o`=000; a `btn_inc_i` before the 3rd pulse restarts the count.
- In `ED_DAY`, `rst` for one cycle → reset values next cycle, no `inc_o` strobe.

Source files
------------

// File: rtl/century_clock_pkg.sv
// Shared definitions for the century clock: edit/run state encoding, the
// field codes the display multiplexer blinks, and the increment strobe bit
// positions the counter core listens to.
package century_clock_pkg;

   typedef enum logic [2:0] {
      RUN_TIME = 3'd0,
      RUN_DATE = 3'd1,
      ED_SEC   = 3'd2,
      ED_MIN   = 3'd3,
      ED_HOUR  = 3'd4,
      ED_DAY   = 3'd5,
      ED_MON   = 3'd6,
      ED_YEAR  = 3'd7
   } state_t;

   // Field codes presented on blink_mode_o.
   localparam logic [2:0] BLINK_NONE = 3'b000;
   localparam logic [2:0] BLINK_SEC  = 3'b001;
   localparam logic [2:0] BLINK_MIN  = 3'b010;
   localparam logic [2:0] BLINK_HOUR = 3'b011;
   localparam logic [2:0] BLINK_DAY  = 3'b100;
   localparam logic [2:0] BLINK_MON  = 3'b101;
   localparam logic [2:0] BLINK_YEAR = 3'b110;

   // Bit positions inside the one-hot increment strobe.
   localparam int INC_W    = 6;
   localparam int INC_SEC  = 0;
   localparam int INC_MIN  = 1;
   localparam int INC_HOUR = 2;
   localparam int INC_DAY  = 3;
   localparam int INC_MON  = 4;
   localparam int INC_YEAR = 5;

   function automatic logic is_edit(input state_t s);
      return !(s == RUN_TIME || s == RUN_DATE);
   endfunction

   // Time group = the states that show the time view.
   function automatic logic is_time(input state_t s);
      return (s == RUN_TIME || s == ED_SEC || s == ED_MIN || s == ED_HOUR);
   endfunction

   function automatic logic [2:0] field_code(input state_t s);
      logic [2:0] c;
      c = BLINK_NONE;
      case (s)
         ED_SEC:  c = BLINK_SEC;
         ED_MIN:  c = BLINK_MIN;
         ED_HOUR: c = BLINK_HOUR;
         ED_DAY:  c = BLINK_DAY;
         ED_MON:  c = BLINK_MON;
         ED_YEAR: c = BLINK_YEAR;
         default: c = BLINK_NONE;
      endcase
      return c;
   endfunction

   function automatic logic [INC_W-1:0] inc_mask(input state_t s);
      logic [INC_W-1:0] m;
      m = '0;
      case (s)
         ED_SEC:  m[INC_SEC]  = 1'b1;
         ED_MIN:  m[INC_MIN]  = 1'b1;
         ED_HOUR: m[INC_HOUR] = 1'b1;
         ED_DAY:  m[INC_DAY]  = 1'b1;
         ED_MON:  m[INC_MON]  = 1'b1;
         ED_YEAR: m[INC_YEAR] = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: while enabled, the phase flips every BLINK_DIV
// cycles. A restart (or disable) forces the phase to "visible" and starts a
// full half-period from zero so a freshly changed field is seen at once.
module blink_gen #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick_blink
);

   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Next counter/phase: hold at zero when idle or restarted, else count and toggle on wrap.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = tick_q;
      if (!en || restart) begin
         cnt_d  = '0;
         tick_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d  = '0;
         tick_d = ~tick_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter and phase registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_blink = tick_q;

endmodule

// File: rtl/edit_controller.sv
// Front-panel sequencer: turns debounced button pulses into display select,
// field blink, counter freeze and field increment controls. Owns the
// run/edit FSM and the edit inactivity timeout; blink phase lives in blink_gen.
// Button pulses are single-cycle strobes with no handshake: each one is
// consumed in the cycle it is seen, and only the highest-priority pulse
// (set > mode > inc > timeout) acts. state_o exposes the FSM state for debug.
module edit_controller
   import century_clock_pkg::*;
#(
   parameter int BLINK_DIV = 25_000_000,
   parameter int TIMEOUT_S = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_mode_i,
   input  logic             btn_set_i,
   input  logic             btn_inc_i,
   input  logic             tick_1hz_i,
   output logic             mode_o,
   output logic [2:0]       blink_mode_o,
   output logic             tick_blink_o,
   output logic             hold_o,
   output logic [INC_W-1:0] inc_o,
   output state_t           state_o
);

   localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_S);

   state_t             state_q, state_d;
   logic [IDLE_W-1:0]  idle_q, idle_d;
   logic [INC_W-1:0]   inc_q, inc_d;
   logic               mode_q;
   logic [2:0]         blink_mode_q;
   logic               hold_q;
   logic               any_btn;
   logic               timeout;
   logic               inc_restart;
   logic               blink_restart;

   assign any_btn = btn_set_i | btn_mode_i | btn_inc_i;

   // Next state, increment strobe and idle count; winner-takes-all on coincident pulses.
   always_comb begin
      state_d     = state_q;
      inc_d       = '0;
      inc_restart = 1'b0;
      timeout     = is_edit(state_q) && tick_1hz_i && (idle_q >= IDLE_LAST);
      if (btn_set_i) begin
         case (state_q)
            RUN_TIME: state_d = ED_SEC;
            ED_SEC:   state_d = ED_MIN;
            ED_MIN:   state_d = ED_HOUR;
            ED_HOUR:  state_d = RUN_TIME;
            RUN_DATE: state_d = ED_DAY;
            ED_DAY:   state_d = ED_MON;
            ED_MON:   state_d = ED_YEAR;
            ED_YEAR:  state_d = RUN_DATE;
            default:  state_d = RUN_TIME;
         endcase
      end else if (btn_mode_i) begin
         case (state_q)
            RUN_TIME: state_d = RUN_DATE;
            RUN_DATE: state_d = RUN_TIME;
            default:  state_d = is_time(state_q) ? RUN_TIME : RUN_DATE;
         endcase
      end else if (btn_inc_i) begin
         if (is_edit(state_q)) begin
            inc_d       = inc_mask(state_q);
            inc_restart = 1'b1;
         end
      end else if (timeout) begin
         state_d = is_time(state_q) ? RUN_TIME : RUN_DATE;
      end

      // Idle seconds only accumulate while sitting in one edit state untouched.
      idle_d = idle_q;
      if (any_btn || !is_edit(state_q) || (state_d != state_q)) begin
         idle_d = '0;
      end else if (tick_1hz_i && (idle_q != IDLE_MAX)) begin
         idle_d = idle_q + 1'b1;
      end
   end

   assign blink_restart = inc_restart || (state_d != state_q);

   // State, idle counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN_TIME;
         idle_q       <= '0;
         inc_q        <= '0;
         mode_q       <= 1'b1;
         blink_mode_q <= BLINK_NONE;
         hold_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idle_q       <= idle_d;
         inc_q        <= inc_d;
         mode_q       <= is_time(state_d);
         blink_mode_q <= field_code(state_d);
         hold_q       <= is_edit(state_d);
      end
   end

   blink_gen #(
      .BLINK_DIV(BLINK_DIV)
   ) u_blink_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (is_edit(state_d)),
      .restart   (blink_restart),
      .tick_blink(tick_blink_o)
   );

   assign mode_o       = mode_q;
   assign blink_mode_o = blink_mode_q;
   assign hold_o       = hold_q;
   assign inc_o        = inc_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_edit_controller.sv
// Bench for edit_controller: directed front-panel scenarios followed by
// random button/tick traffic, checked every cycle against a reference model
// that tracks group, field index, idle seconds and blink age.
module tb_edit_controller;
   import century_clock_pkg::*;

   localparam int BLINK_DIV = 4;
   localparam int TIMEOUT_S = 3;
   localparam int VW = 12;

   // Clock and reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_mode = 1'b0, btn_set = 1'b0, btn_inc = 1'b0, tick_1hz = 1'b0;
   logic mode_o, tick_blink_o, hold_o;
   logic [2:0] blink_mode_o;
   logic [5:0] inc_o;
   state_t state_o;

   always #5 clk = ~clk;

   edit_controller #(
      .BLINK_DIV(BLINK_DIV),
      .TIMEOUT_S(TIMEOUT_S)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_mode_i  (btn_mode),
      .btn_set_i   (btn_set),
      .btn_inc_i   (btn_inc),
      .tick_1hz_i  (tick_1hz),
      .mode_o      (mode_o),
      .blink_mode_o(blink_mode_o),
      .tick_blink_o(tick_blink_o),
      .hold_o      (hold_o),
      .inc_o       (inc_o),
      .state_o     (state_o)
   );

   // Scoreboard
   logic [VW-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Reference model: grp 1 = time group; fld 0 = running, 1..3 = field within group.
   logic m_grp = 1'b1;
   int   m_fld = 0;
   int   m_idle = 0;
   int   m_age = 0;

   task automatic model(input logic s, input logic m, input logic i, input logic t, input logic r);
      int         nfld;
      logic       ngrp;
      logic [5:0] inc;
      bit         restart, edit, changed;
      logic [2:0] code;
      logic       blink;
      if (r) begin
         m_grp = 1'b1; m_fld = 0; m_idle = 0; m_age = 0;
         exp_q.push_back({1'b1, 3'd0, 1'b0, 1'b0, 6'd0});
         return;
      end
      edit = (m_fld != 0);
      nfld = m_fld; ngrp = m_grp; inc = '0; restart = 0;
      if (s) begin
         nfld = edit ? ((m_fld == 3) ? 0 : m_fld + 1) : 1;
      end else if (m) begin
         if (edit) nfld = 0;
         else ngrp = ~m_grp;
      end else if (i) begin
         if (edit) begin
            inc = 6'd1 << ((m_grp ? m_fld : m_fld + 3) - 1);
            restart = 1;
         end
      end else if (t && edit && (m_idle + 1 >= TIMEOUT_S)) begin
         nfld = 0;
      end
      changed = (nfld != m_fld) || (ngrp != m_grp);
      if (s || m || i || changed || !edit) m_idle = 0;
      else if (t) m_idle = m_idle + 1;
      if (nfld != 0 && (changed || restart)) m_age = 0;
      else if (nfld != 0) m_age = m_age + 1;
      else m_age = 0;
      m_fld = nfld; m_grp = ngrp;
      code = (m_fld == 0) ? 3'd0 : 3'(m_grp ? m_fld : m_fld + 3);
      blink = (m_fld != 0) && (((m_age / BLINK_DIV) % 2) == 1);
      exp_q.push_back({m_grp, code, blink, (m_fld != 0), inc});
   endtask

   // Driver: apply one cycle of inputs on the falling edge and record the expectation.
   task automatic step(input logic s, input logic m, input logic i, input logic t, input logic r);
      @(negedge clk);
      btn_set = s; btn_mode = m; btn_inc = i; tick_1hz = t; rst = r;
      model(s, m, i, t, r);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle the DUT presents a full output vector; compare just after the edge.
   always @(posedge clk) begin
      logic [VW-1:0] exp_v, act_v;
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         act_v = {mode_o, blink_mode_o, tick_blink_o, hold_o, inc_o};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs cycle=%0d actual mode=%b blink_mode=%b tick_blink=%b hold=%b inc=%b required mode=%b blink_mode=%b tick_blink=%b hold=%b inc=%b",
                     cyc, act_v[11], act_v[10:8], act_v[7], act_v[6], act_v[5:0],
                     exp_v[11], exp_v[10:8], exp_v[7], exp_v[6], exp_v[5:0]);
         end
      end
   end

   // Stimulus and final report
   initial begin
      int wait_cnt;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      idle(2);
      // View toggle
      step(0, 1, 0, 0, 0); idle(2);
      step(0, 1, 0, 0, 0); idle(2);
      // Walk the time edit chain back to RUN_TIME
      for (int k = 0; k < 4; k++) begin step(1, 0, 0, 0, 0); idle(2); end
      // Date group: into ED_MON, two increments with blink observation
      step(0, 1, 0, 0, 0); idle(1);
      step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); idle(2);
      step(0, 0, 1, 0, 0); idle(6);
      step(0, 0, 1, 0, 0); idle(9);
      // ED_YEAR timeout, with an increment restarting the count
      step(1, 0, 0, 0, 0); idle(1);
      step(0, 0, 0, 1, 0); idle(1); step(0, 0, 0, 1, 0); idle(1);
      step(0, 0, 1, 0, 0); idle(1);
      step(0, 0, 0, 1, 0); idle(1); step(0, 0, 0, 1, 0); idle(1);
      step(0, 0, 0, 1, 0); idle(3);
      // Set and inc together in ED_HOUR
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); idle(1);
      step(1, 0, 1, 0, 0); idle(2);
      // Reset mid-edit in ED_DAY
      step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0); idle(2);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1); idle(2);
      // Random traffic: busy phase, then sparse buttons with frequent ticks
      for (int k = 0; k < 1500; k++)
         step($urandom_range(99) < 6, $urandom_range(99) < 5, $urandom_range(99) < 12,
              $urandom_range(99) < 10, $urandom_range(499) == 0);
      for (int k = 0; k < 1500; k++)
         step($urandom_range(99) < 2, $urandom_range(199) == 0, $urandom_range(99) < 2,
              $urandom_range(99) < 35, $urandom_range(999) == 0);
      @(negedge clk);
      btn_set = 0; btn_mode = 0; btn_inc = 0; tick_1hz = 0; rst = 0;
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
